rgb2gray: RTL and testbench

Front-end stage that converts a 256x256 RGB frame into an 8-bit grayscale frame. It writes the result into the gray SRAM that the image-filter stage reads. It fetches one 24-bit pixel per cycle from the RGB source memory, computes a fixed-weight luminance, and writes it to the same address in gray SRAM. When the whole frame is written it raises `gray_ready`, the start condition for the downstream filter.

---
 rtl/rgb2gray_if.sv | 26 ++
 rtl/rgb2gray.sv | 122 ++++++++++++
 tb/tb_rgb2gray.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rgb2gray_if.sv
// Bus bundle between rgb2gray and its RGB source memory / gray SRAM / filter.
// master = converter side, slave = memory and downstream side.
interface rgb2gray_if #(
  parameter int unsigned In_Width   = 8,
  parameter int unsigned Out_Width  = 8,
  parameter int unsigned Addr_Width = 16
);
  logic                    rgb_ready;
  logic                    rgb_req;
  logic [Addr_Width-1:0]   rgb_addr;
  logic [3*In_Width-1:0]   rgb_data;
  logic                    gray_wen;
  logic [Addr_Width-1:0]   gray_waddr;
  logic [Out_Width-1:0]    gray_wdata;
  logic                    gray_ready;

  modport master (
    input  rgb_ready, rgb_data,
    output rgb_req, rgb_addr, gray_wen, gray_waddr, gray_wdata, gray_ready
  );

  modport slave (
    output rgb_ready, rgb_data,
    input  rgb_req, rgb_addr, gray_wen, gray_waddr, gray_wdata, gray_ready
  );
endinterface

// File: rtl/rgb2gray.sv
// Streams a 256x256 RGB frame into 8-bit luminance (77R+150G+29B)/256, one pixel per cycle.
// Optional RGB2GRAY_ROUND_EN: round-to-nearest instead of truncation, same timing.
module rgb2gray #(
  parameter int unsigned In_Width   = 8,
  parameter int unsigned Out_Width  = 8,
  parameter int unsigned Addr_Width = 16
) (
  input  logic         clk,
  input  logic         rst,
  rgb2gray_if.master   bus
);

  localparam int unsigned ProdW = In_Width + 8;
  localparam logic [Addr_Width-1:0] LastAddr = {Addr_Width{1'b1}};
  localparam logic [7:0] WeightR = 8'd77;
  localparam logic [7:0] WeightG = 8'd150;
  localparam logic [7:0] WeightB = 8'd29;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                  state;
  logic                    rd_valid;
  logic [Addr_Width-1:0]   rd_addr;
  logic                    p_valid;
  logic [Addr_Width-1:0]   p_addr;
  logic [ProdW-1:0]        p_r;
  logic [ProdW-1:0]        p_g;
  logic [ProdW-1:0]        p_b;
  logic [ProdW-1:0]        sum_c;
  logic [Out_Width-1:0]    gray_c;

  logic [In_Width-1:0]     chan_r;
  logic [In_Width-1:0]     chan_g;
  logic [In_Width-1:0]     chan_b;

  assign chan_r = bus.rgb_data[3*In_Width-1 -: In_Width];
  assign chan_g = bus.rgb_data[2*In_Width-1 -: In_Width];
  assign chan_b = bus.rgb_data[In_Width-1   -: In_Width];

  // Weights sum to 256, so the top byte of the weighted sum is the luminance.
  always_comb begin
    sum_c  = '0;
    gray_c = '0;
`ifdef RGB2GRAY_ROUND_EN
    sum_c  = p_r + p_g + p_b + ProdW'(128);
`else
    sum_c  = p_r + p_g + p_b;
`endif
    gray_c = Out_Width'(sum_c >> 8);
  end

  // Frame sequencer, address counter and three-stage datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.rgb_req    <= 1'b0;
      bus.rgb_addr   <= '0;
      rd_valid       <= 1'b0;
      rd_addr        <= '0;
      p_valid        <= 1'b0;
      p_addr         <= '0;
      p_r            <= '0;
      p_g            <= '0;
      p_b            <= '0;
      bus.gray_wen   <= 1'b0;
      bus.gray_waddr <= '0;
      bus.gray_wdata <= '0;
      bus.gray_ready <= 1'b0;
    end else begin
      rd_valid <= bus.rgb_req;
      rd_addr  <= bus.rgb_addr;

      p_valid <= rd_valid;
      if (rd_valid) begin
        p_r    <= ProdW'(chan_r) * ProdW'(WeightR);
        p_g    <= ProdW'(chan_g) * ProdW'(WeightG);
        p_b    <= ProdW'(chan_b) * ProdW'(WeightB);
        p_addr <= rd_addr;
      end

      bus.gray_wen <= p_valid;
      if (p_valid) begin
        bus.gray_waddr <= p_addr;
        bus.gray_wdata <= gray_c;
      end

      case (state)
        IDLE: begin
          if (bus.rgb_ready) begin
            state        <= FETCH;
            bus.rgb_req  <= 1'b1;
            bus.rgb_addr <= '0;
          end
        end
        FETCH: begin
          // Counter holds at the last address; the frame is never re-issued.
          if (bus.rgb_addr == LastAddr) begin
            state       <= DRAIN;
            bus.rgb_req <= 1'b0;
          end else begin
            bus.rgb_addr <= bus.rgb_addr + Addr_Width'(1);
          end
        end
        DRAIN: begin
          if (bus.gray_wen && (bus.gray_waddr == LastAddr)) begin
            state          <= DONE;
            bus.gray_ready <= 1'b1;
          end
        end
        DONE: begin
          bus.gray_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2gray.sv
// Directed bench for rgb2gray: reset/idle, aborted frame, full frame with hand-computed pixels.
module tb_rgb2gray;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   failures;

`ifdef RGB2GRAY_ROUND_EN
  localparam logic [7:0] GrayRed  = 8'd77;
  localparam logic [7:0] GrayBlue = 8'd29;
`else
  localparam logic [7:0] GrayRed  = 8'd76;
  localparam logic [7:0] GrayBlue = 8'd28;
`endif
  localparam logic [7:0] GrayGreen = 8'd149;
  localparam logic [7:0] GrayGrey  = 8'd100;
  localparam logic [7:0] GrayWhite = 8'd255;

  rgb2gray_if #(.In_Width(8), .Out_Width(8), .Addr_Width(16)) bus ();

  rgb2gray #(.In_Width(8), .Out_Width(8), .Addr_Width(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [15:0] a);
    case (a)
      16'h0000: pix = 24'hFF0000;
      16'h0001: pix = 24'h0000FF;
      16'h0002: pix = 24'h00FF00;
      16'hFFFF: pix = 24'hFFFFFF;
      default:  pix = 24'h646464;
    endcase
  endfunction

  function automatic logic [7:0] exp_gray(input logic [15:0] a);
    case (a)
      16'h0000: exp_gray = GrayRed;
      16'h0001: exp_gray = GrayBlue;
      16'h0002: exp_gray = GrayGreen;
      16'hFFFF: exp_gray = GrayWhite;
      default:  exp_gray = GrayGrey;
    endcase
  endfunction

  // RGB source memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rgb_req) bus.rgb_data <= pix(bus.rgb_addr);
  end

  function automatic logic [63:0] outs();
    outs = {21'b0, bus.rgb_req, bus.rgb_addr, bus.gray_wen, bus.gray_waddr,
            bus.gray_wdata, bus.gray_ready};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Accepts a frame, then observes n cycles; k counts cycles after the accepting one.
  task automatic run_frame(input int n);
    int err_rd;
    int err_wr;
    int err_rdy;
    logic exp_req;
    logic exp_wen;
    err_rd  = 0;
    err_wr  = 0;
    err_rdy = 0;
    @(negedge clk);
    bus.rgb_ready = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      exp_req = (k <= 65536);
      exp_wen = (k >= 4) && (k <= 65539);
      if (bus.rgb_req !== exp_req || (exp_req && bus.rgb_addr !== 16'(k - 1))) err_rd++;
      if (bus.gray_wen !== exp_wen ||
          (exp_wen && (bus.gray_waddr !== 16'(k - 4) ||
                       bus.gray_wdata !== exp_gray(16'(k - 4))))) err_wr++;
      if (bus.gray_ready !== (k >= 65540)) err_rdy++;

      if (k == 1)     check("first_req",   {bus.rgb_req, bus.rgb_addr}, {1'b1, 16'h0000});
      if (k == 3)     check("no_early_wr", 64'(bus.gray_wen), 64'd0);
      if (k == 4)     check("pix0_gray",   {bus.gray_wen, bus.gray_waddr, bus.gray_wdata}, {1'b1, 16'd0, GrayRed});
      if (k == 5)     check("pix1_gray",   {bus.gray_wen, bus.gray_waddr, bus.gray_wdata}, {1'b1, 16'd1, GrayBlue});
      if (k == 6)     check("pix2_gray",   {bus.gray_wen, bus.gray_waddr, bus.gray_wdata}, {1'b1, 16'd2, GrayGreen});
      if (k == 104)   check("pulse_ignored", {bus.rgb_req, bus.rgb_addr}, {1'b1, 16'd103});
      if (k == 65536) check("last_req",    {bus.rgb_req, bus.rgb_addr}, {1'b1, 16'hFFFF});
      if (k == 65537) check("req_off",     64'(bus.rgb_req), 64'd0);
      if (k == 65539) check("last_write",  {bus.gray_wen, bus.gray_waddr, bus.gray_wdata, bus.gray_ready},
                                           {1'b1, 16'hFFFF, 8'hFF, 1'b0});
      if (k == 65540) check("after_last",  {bus.gray_wen, bus.gray_ready, bus.rgb_req}, {1'b0, 1'b1, 1'b0});
      if (k == n && k > 65540) check("done_hold", {bus.rgb_req, bus.gray_wen, bus.gray_ready}, {1'b0, 1'b0, 1'b1});

      bus.rgb_ready = ((k >= 100) && (k <= 102)) || (k >= 65541);
    end
    check("rd_stream_errs",  64'(err_rd),  64'd0);
    check("wr_stream_errs",  64'(err_wr),  64'd0);
    check("rdy_stream_errs", 64'(err_rdy), 64'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.rgb_ready = 1'b0;
    bus.rgb_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", outs(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", outs(), 64'd0);
    end

    // Abort a frame part-way; reset must clear outputs asynchronously.
    run_frame(10001);
    rst = 1'b1;
    #1;
    check("abort_rst_outs", outs(), 64'd0);
    bus.rgb_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_abort_idle", outs(), 64'd0);
    end

    // Full frame, with rgb_ready pulsed mid-fetch and held through DONE.
    run_frame(65560);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
